// File: rtl/card_hand_bank_if.sv
// Handshake and readout bundle between the game FSM / display side (master) and the card hand bank (slave).
interface card_hand_bank_if #(
    parameter int NUM_HANDS      = 2,
    parameter int CARDS_PER_HAND = 3
);
    localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1;
    localparam int CW = $clog2(CARDS_PER_HAND + 1);

    logic                                  new_round;
    logic                                  deal_req;
    logic [HW-1:0]                         deal_hand;
    logic                                  force_en;
    logic [3:0]                            force_card;
    logic                                  deal_ack;
    logic                                  deal_err;
    logic [3:0]                            last_card;
    logic [NUM_HANDS*CARDS_PER_HAND*4-1:0] cards_flat;
    logic [NUM_HANDS*CW-1:0]               counts_flat;
    logic [NUM_HANDS*4-1:0]                scores_flat;
    logic [NUM_HANDS-1:0]                  hand_full;

    modport master (
        output new_round, deal_req, deal_hand, force_en, force_card,
        input  deal_ack, deal_err, last_card, cards_flat, counts_flat, scores_flat, hand_full
    );

    modport slave (
        input  new_round, deal_req, deal_hand, force_en, force_card,
        output deal_ack, deal_err, last_card, cards_flat, counts_flat, scores_flat, hand_full
    );
endinterface

// File: rtl/card_hand_bank.sv
// Baccarat hand storage: appends one drawn card per cycle to a hand and keeps a registered mod-10 score.
// Latency: state visible after the accepting edge, ack/err/last_card for one cycle after it; never stalls.
module card_hand_bank #(
    parameter int NUM_HANDS      = 2,
    parameter int CARDS_PER_HAND = 3
) (
    input logic             slow_clock,
    input logic             reset,
    card_hand_bank_if.slave bus
);
    localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1;
    localparam int CW = $clog2(CARDS_PER_HAND + 1);

    logic [3:0]    src;
    logic [3:0]    slot_q  [NUM_HANDS][CARDS_PER_HAND];
    logic [CW-1:0] cnt_q   [NUM_HANDS];
    logic [3:0]    score_q [NUM_HANDS];
    logic          ack_q;
    logic          err_q;
    logic [3:0]    last_q;

    logic [3:0]    card;
    logic [3:0]    pts;
    logic [3:0]    cur_score;
    logic [3:0]    new_score;
    logic [CW-1:0] cur_cnt;
    logic [4:0]    sum;
    logic          hand_ok;
    logic          card_ok;
    logic          room;
    logic          accept;

    assign card    = bus.force_en ? bus.force_card : src;
    assign card_ok = !bus.force_en || (bus.force_card != 4'd0 && bus.force_card <= 4'd13);

    // A power-of-two hand count makes every index legal; only otherwise is a range check needed.
    generate
        if ((1 << HW) == NUM_HANDS) begin : g_all_valid
            assign hand_ok = 1'b1;
        end else begin : g_range_chk
            assign hand_ok = (bus.deal_hand < HW'(NUM_HANDS));
        end
    endgenerate

    always_comb begin
        cur_cnt   = '0;
        cur_score = '0;
        for (int h = 0; h < NUM_HANDS; h++) begin
            if (bus.deal_hand == HW'(h)) begin
                cur_cnt   = cnt_q[h];
                cur_score = score_q[h];
            end
        end
    end

    assign room      = (cur_cnt < CW'(CARDS_PER_HAND));
    assign pts       = (card <= 4'd9) ? card : 4'd0;
    assign sum       = {1'b0, cur_score} + {1'b0, pts};
    assign new_score = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
    assign accept    = bus.deal_req && !bus.new_round && hand_ok && room && card_ok;

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            src    <= 4'd1;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            last_q <= 4'd0;
            for (int h = 0; h < NUM_HANDS; h++) begin
                cnt_q[h]   <= '0;
                score_q[h] <= 4'd0;
                for (int s = 0; s < CARDS_PER_HAND; s++) slot_q[h][s] <= 4'd0;
            end
        end else begin
            src   <= (src == 4'd13) ? 4'd1 : src + 4'd1;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (bus.new_round) begin
                // A deal arriving with new_round is dropped silently, so last_card keeps its value.
                for (int h = 0; h < NUM_HANDS; h++) begin
                    cnt_q[h]   <= '0;
                    score_q[h] <= 4'd0;
                    for (int s = 0; s < CARDS_PER_HAND; s++) slot_q[h][s] <= 4'd0;
                end
            end else if (bus.deal_req) begin
                ack_q  <= 1'b1;
                err_q  <= !accept;
                last_q <= accept ? card : 4'd0;
                for (int h = 0; h < NUM_HANDS; h++) begin
                    if (accept && bus.deal_hand == HW'(h)) begin
                        cnt_q[h]   <= cnt_q[h] + 1'b1;
                        score_q[h] <= new_score;
                        for (int s = 0; s < CARDS_PER_HAND; s++) begin
                            if (cnt_q[h] == CW'(s)) slot_q[h][s] <= card;
                        end
                    end
                end
            end
        end
    end

    assign bus.deal_ack  = ack_q;
    assign bus.deal_err  = err_q;
    assign bus.last_card = last_q;

    generate
        for (genvar h = 0; h < NUM_HANDS; h++) begin : g_hand
            assign bus.counts_flat[h*CW +: CW] = cnt_q[h];
            assign bus.scores_flat[h*4 +: 4]   = score_q[h];
            assign bus.hand_full[h]            = (cnt_q[h] == CW'(CARDS_PER_HAND));
            for (genvar s = 0; s < CARDS_PER_HAND; s++) begin : g_slot
                assign bus.cards_flat[(h*CARDS_PER_HAND+s)*4 +: 4] = slot_q[h][s];
            end
        end
    endgenerate
endmodule
